// File: rtl/adder_tree_acc_pkg.sv
// adder_tree_acc_pkg: sizing helpers and lane extension shared by the adder tree and its accumulator.
package adder_tree_acc_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_lat(input int p);
        return (clog2(p) < 1) ? 1 : clog2(p);
    endfunction

    function automatic int tree_w(input int dw, input int p);
        return dw + clog2(p);
    endfunction

    function automatic int dout_w(input int dw, input int p, input int lw);
        return tree_w(dw, p) + lw;
    endfunction

    // Fill bit used when widening an operand: its MSB when signed, zero otherwise.
    function automatic logic ext_bit(input logic msb, input bit sgn);
        return sgn & msb;
    endfunction

endpackage

// File: rtl/adder_tree_acc_level.sv
// adder_tree_level: one registered reduction level, N operands of width W into ceil(N/2) of width W+1.
module adder_tree_level
    import adder_tree_acc_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 8,
    parameter bit SIGNED = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N*W-1:0]                 din_i,
    output logic [((N+1)/2)*(W+1)-1:0]     dout_o
);

    localparam int M = (N + 1) / 2;

    logic [M*(W+1)-1:0] sum_d, sum_q;

    for (genvar k = 0; k < N / 2; k++) begin : g_pair
        logic [W-1:0] a, b;
        assign a = din_i[2*k*W +: W];
        assign b = din_i[(2*k+1)*W +: W];
        assign sum_d[k*(W+1) +: W+1] = {ext_bit(a[W-1], SIGNED), a} + {ext_bit(b[W-1], SIGNED), b};
    end

    // An odd leftover operand is only widened so every output shares one width.
    if (N % 2 == 1) begin : g_odd
        logic [W-1:0] a;
        assign a = din_i[(N-1)*W +: W];
        assign sum_d[(M-1)*(W+1) +: W+1] = {ext_bit(a[W-1], SIGNED), a};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign dout_o = sum_q;

endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined lane adder tree feeding an integrate-and-dump frame accumulator.
module adder_tree_acc
    import adder_tree_acc_pkg::*;
#(
    parameter int DIN_WIDTH     = 8,
    parameter int PARALLEL      = 10,
    parameter bit SIGNED        = 1,
    parameter int ACC_LEN_WIDTH = 16,
    localparam int TREE_W       = tree_w(DIN_WIDTH, PARALLEL),
    localparam int DOUT_WIDTH   = dout_w(DIN_WIDTH, PARALLEL, ACC_LEN_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    input  logic                          sync_in,
    input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
    output logic [TREE_W-1:0]             tree_out,
    output logic                          tree_valid,
    output logic [DOUT_WIDTH-1:0]         dout,
    output logic                          dout_valid
);

    localparam int LEVELS   = clog2(PARALLEL);
    localparam int TREE_LAT = tree_lat(PARALLEL);
    localparam logic [ACC_LEN_WIDTH:0] ONE = 1;

    if (PARALLEL == 1) begin : g_single
        logic [DIN_WIDTH-1:0] tree_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) tree_q <= '0;
            else     tree_q <= din;
        end
        assign tree_out = tree_q;
    end else begin : g_tree
        for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
            localparam int N = (PARALLEL + (1 << i) - 1) >> i;
            localparam int W = DIN_WIDTH + i;
            logic [((N+1)/2)*(W+1)-1:0] q;
            if (i == 0) begin : g_in
                adder_tree_level #(.N(N), .W(W), .SIGNED(SIGNED)) u_lvl (
                    .clk(clk), .rst(rst), .din_i(din), .dout_o(q));
            end else begin : g_in
                adder_tree_level #(.N(N), .W(W), .SIGNED(SIGNED)) u_lvl (
                    .clk(clk), .rst(rst), .din_i(g_lvl[i-1].q), .dout_o(q));
            end
        end
        assign tree_out = g_lvl[LEVELS-1].q;
    end

    logic [TREE_LAT-1:0] vld_q, syn_q;
    logic                sync_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            syn_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | TREE_LAT'(din_valid);
            syn_q <= (syn_q << 1) | TREE_LAT'(sync_in);
        end
    end

    assign tree_valid = vld_q[TREE_LAT-1];
    assign sync_dly   = syn_q[TREE_LAT-1];

    logic [DOUT_WIDTH-1:0]    acc_d, acc_q, dout_d, dout_q, tree_ext;
    logic [ACC_LEN_WIDTH-1:0] cnt_d, cnt_q, len_d, len_q;
    logic [ACC_LEN_WIDTH:0]   cnt_inc;
    logic                     start, dump, dv_q;

    // The count is compared one bit wider so acc_len at full scale still terminates.
    always_comb begin
        tree_ext = {{ACC_LEN_WIDTH{ext_bit(tree_out[TREE_W-1], SIGNED)}}, tree_out};
        start    = (cnt_q == '0) || sync_dly;
        len_d    = (tree_valid && start) ? acc_len : len_q;
        cnt_inc  = start ? ONE : {1'b0, cnt_q} + ONE;
        dump     = tree_valid && (cnt_inc == {1'b0, len_d} + ONE);
        acc_d    = !tree_valid ? acc_q : start ? tree_ext : acc_q + tree_ext;
        cnt_d    = dump ? '0 : tree_valid ? cnt_inc[ACC_LEN_WIDTH-1:0] : sync_dly ? '0 : cnt_q;
        dout_d   = dump ? acc_d : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            dout_q <= dout_d;
            dv_q   <= dump;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: vector table, hand-written frame sequences and a random run against a frame-level model.
module tb_adder_tree_acc;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] din10 = '0;
    logic [23:0] din3 = '0;
    logic [3:0]  din1 = '0;
    logic        din_valid = 1'b0;
    logic        sync_in = 1'b0;
    logic [15:0] acc_len = '0;

    logic [11:0] tree_out, tree_u;
    logic [27:0] dout, dout_u;
    logic        tree_valid, dout_valid, tv_u, dv_u;
    logic [9:0]  t3;
    logic [25:0] d3;
    logic        tv3, dv3;
    logic [3:0]  t1;
    logic [19:0] d1;
    logic        tv1, dv1;

    always #5 clk = ~clk;

    adder_tree_acc #(.DIN_WIDTH(8), .PARALLEL(10), .SIGNED(1), .ACC_LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .din(din10), .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len),
        .tree_out(tree_out), .tree_valid(tree_valid), .dout(dout), .dout_valid(dout_valid));

    adder_tree_acc #(.DIN_WIDTH(8), .PARALLEL(10), .SIGNED(0), .ACC_LEN_WIDTH(16)) u10u (
        .clk(clk), .rst(rst), .din(din10), .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len),
        .tree_out(tree_u), .tree_valid(tv_u), .dout(dout_u), .dout_valid(dv_u));

    adder_tree_acc #(.DIN_WIDTH(8), .PARALLEL(3), .SIGNED(0), .ACC_LEN_WIDTH(16)) u3 (
        .clk(clk), .rst(rst), .din(din3), .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len),
        .tree_out(t3), .tree_valid(tv3), .dout(d3), .dout_valid(dv3));

    adder_tree_acc #(.DIN_WIDTH(4), .PARALLEL(1), .SIGNED(1), .ACC_LEN_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len),
        .tree_out(t1), .tree_valid(tv1), .dout(d1), .dout_valid(dv1));

    typedef struct {
        logic [7:0] lane;
        logic [3:0] lane4;
        int         e10s;
        int         e10u;
        int         e3u;
        int         e1s;
    } vec_t;

    typedef struct {
        bit v;
        bit s;
        int sum;
    } tr_t;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    tr_t    pq[$];
    tr_t    cur;
    int     m_cnt, m_len;
    longint m_acc, m_dout;
    bit     m_dv;
    longint dq[$];
    int     dc[$];
    vec_t   tv[5];

    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        repeat (L - 1) pq.push_back('{0, 0, 0});
        cur = '{0, 0, 0};
        m_cnt = 0; m_len = 0; m_acc = 0; m_dout = 0; m_dv = 0;
        dq.delete(); dc.delete();
    endtask

    // Frame model: tree output is the lane sum seen L cycles earlier; frames follow the dump rules.
    task automatic step();
        int s = 0;
        int al;
        for (int k = 0; k < 10; k++) s += int'($signed(din10[k*8 +: 8]));
        pq.push_back('{din_valid, sync_in, s});
        al = int'(acc_len);
        @(posedge clk); #1;
        cyc++;
        if (cur.v) begin
            if (m_cnt == 0 || cur.s) begin
                m_acc = cur.sum; m_cnt = 1; m_len = al;
            end else begin
                m_acc += cur.sum; m_cnt++;
            end
            m_dv = (m_cnt == m_len + 1);
            if (m_dv) begin m_dout = m_acc; m_cnt = 0; end
        end else begin
            m_dv = 0;
            if (cur.s) m_cnt = 0;
        end
        cur = pq.pop_front();
        chk("tree_valid", tree_valid, cur.v);
        if (cur.v) chk("tree_out", $signed(tree_out), cur.sum);
        chk("dout_valid", dout_valid, m_dv);
        chk("dout", $signed(dout), m_dout);
        if (dout_valid) begin
            dq.push_back(longint'($signed(dout)));
            dc.push_back(cyc);
        end
    endtask

    task automatic beat(input bit v, input bit s, input logic [7:0] lane);
        din10 = {10{lane}};
        din_valid = v;
        sync_in = s;
        step();
    endtask

    task automatic do_reset();
        din_valid = 0; sync_in = 0;
        rst = 1; #2; rst = 0;
        model_reset();
    endtask

    task automatic expect_dumps(input string n, input int cnt, input longint val, input int gap);
        chk({n, "_count"}, dq.size(), cnt);
        foreach (dq[i]) chk({n, "_value"}, dq[i], val);
        for (int i = 1; i < dc.size(); i++) chk({n, "_gap"}, dc[i] - dc[i-1], gap);
    endtask

    initial begin
        tv[0] = '{8'h80, 4'h8, -1280, 1280, 384, -8};
        tv[1] = '{8'hFF, 4'hF, -10, 2550, 765, -1};
        tv[2] = '{8'h01, 4'h1, 10, 10, 3, 1};
        tv[3] = '{8'h7F, 4'h7, 1270, 1270, 381, 7};
        tv[4] = '{8'h00, 4'h0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tree_out", tree_out, 0);
        chk("rst_tree_valid", tree_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        rst = 0;
        model_reset();

        foreach (tv[i]) begin
            din10 = {10{tv[i].lane}}; din3 = {3{tv[i].lane}}; din1 = tv[i].lane4;
            din_valid = 1; acc_len = 0;
            step();
            chk("p1_tree", $signed(t1), tv[i].e1s);
            chk("p1_valid", tv1, 1);
            din_valid = 0;
            step();
            chk("p3_tree", t3, tv[i].e3u);
            chk("p3_valid", tv3, 1);
            chk("p1_dout", $signed(d1), tv[i].e1s);
            chk("p1_dv", dv1, 1);
            step(); step();
            chk("p10s_tree", $signed(tree_out), tv[i].e10s);
            chk("p10u_tree", tree_u, tv[i].e10u);
            chk("p10u_valid", tv_u, 1);
            step();
            chk("p10s_dout", $signed(dout), tv[i].e10s);
            chk("p10s_dv", dout_valid, 1);
            chk("p10u_dout", dout_u, tv[i].e10u);
            chk("p3_dout", d3, tv[i].e3u);
            step();
            chk("p10s_dv_pulse", dout_valid, 0);
        end

        do_reset(); acc_len = 3;
        repeat (16) beat(1, 0, 8'h01);
        repeat (6) beat(0, 0, 8'h01);
        expect_dumps("cont", 4, 40, 4);

        do_reset(); acc_len = 3;
        for (int j = 0; j < 32; j++) beat(j % 2 == 0, 0, 8'h01);
        repeat (6) beat(0, 0, 8'h01);
        expect_dumps("toggle", 4, 40, 8);

        do_reset(); acc_len = 3;
        for (int j = 0; j < 6; j++) beat(1, j == 2, 8'h01);
        repeat (6) beat(0, 0, 8'h01);
        expect_dumps("sync", 1, 40, 0);

        do_reset();
        for (int j = 0; j < 8; j++) begin
            acc_len = (j < 5) ? 16'd3 : 16'd1;
            beat(1, 0, 8'h01);
        end
        repeat (6) beat(0, 0, 8'h01);
        chk("len_change_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("len_change_0", dq[0], 40);
            chk("len_change_1", dq[1], 20);
            chk("len_change_2", dq[2], 20);
        end

        do_reset(); acc_len = 3;
        repeat (2) beat(1, 0, 8'h01);
        #2 rst = 1;
        #1;
        chk("arst_tree_out", tree_out, 0);
        chk("arst_tree_valid", tree_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_p1_tree", t1, 0);
        #1 rst = 0;
        model_reset();
        repeat (4) beat(1, 0, 8'h01);
        repeat (6) beat(0, 0, 8'h01);
        expect_dumps("post_rst", 1, 40, 0);

        do_reset(); acc_len = 2;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 19) == 0) acc_len = 16'($urandom_range(0, 3));
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 3))
                    0: din10[k*8 +: 8] = 8'h80;
                    1: din10[k*8 +: 8] = 8'h7F;
                    default: din10[k*8 +: 8] = 8'($urandom);
                endcase
            end
            din_valid = $urandom_range(0, 3) != 0;
            sync_in = $urandom_range(0, 19) == 0;
            step();
        end
        repeat (6) beat(0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Parametrised, fully pipelined signed/unsigned adder tree that reduces PARALLEL lanes per cycle to one sum.
- The tree feeds an integrate-and-dump accumulator that sums a programmable number of valid tree outputs, then emits one result per frame.
- Used in the AGC/power-estimation path after the per-lane power stage.
- Next generation of the plain adder tree:
  - any PARALLEL ≥ 1, odd lane counts handled correctly;
  - selectable signedness;
  - async reset;
  - frame sync and runtime accumulation length.

Parameters:
- DIN_WIDTH, 8, width of one input lane.
- PARALLEL, 10, number of lanes (≥ 1).
- SIGNED, 1, 1 = lanes are two's complement and are sign-extended; 0 = unsigned and zero-extended.
- ACC_LEN_WIDTH, 16, width of acc_len and of the internal sample counter.
- Derived TREE_W = DIN_WIDTH + clog2(PARALLEL).
- Derived TREE_LAT = max(1, clog2(PARALLEL)).
- Derived DOUT_WIDTH = TREE_W + ACC_LEN_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DIN_WIDTH*PARALLEL  lanes, lane k at din[k*DIN_WIDTH +: DIN_WIDTH].
- din_valid  in  1  din qualifier.
- sync_in  in  1  frame restart, sampled with din.
- acc_len  in  ACC_LEN_WIDTH  frame length minus 1 (frame length = acc_len+1 valid samples).
- tree_out  out  TREE_W  per-cycle tree sum.
- tree_valid  out  1  tree_out qualifier.
- dout  out  DOUT_WIDTH  accumulated frame sum.
- dout_valid  out  1  one-cycle strobe per completed frame.

Behaviour:
- Reset: every register clears asynchronously to 0, including tree data, valid/sync delay lines, counter, accumulator, dout and dout_valid. A frame in progress is discarded; the first valid sample after reset release starts a new frame.
- Tree structure:
  - Each level maps N operands of width W to ceil(N/2) operands of width W+1, every output registered.
  - For odd N, the last operand is registered and extended (sign or zero per SIGNED) to W+1.
  - PARALLEL = 1 is a single register stage.
- Tree latency and timing:
  - Latency is exactly TREE_LAT cycles from din to tree_out.
  - Data registers are free-running; tree_out is don't-care while tree_valid = 0.
  - tree_valid and the internal sync are din_valid and sync_in delayed TREE_LAT cycles through shift registers reset to 0.
- Arithmetic: no overflow is possible by construction. tree_out is exact for all inputs, e.g. SIGNED=1, DIN=8, PARALLEL=10, all −128 gives −1280.
- Accumulator, on each cycle with tree_valid = 1:
  - If cnt == 0 or delayed sync = 1: acc ← ext(tree_out), cnt ← 1, len_q ← acc_len. The sample is the first of a new frame, and any partial frame is dropped with no dout_valid.
  - Otherwise: acc ← acc + ext(tree_out), cnt ← cnt + 1.
  - When the sample just taken makes cnt_next == len_q + 1: dout ← final sum, dout_valid ← 1 for one cycle, cnt ← 0. When acc_len = 0, every valid sample dumps.
- Accumulator, other cases:
  - tree_valid = 0: hold acc/cnt. Gaps in din_valid stretch a frame and never shorten it.
  - Delayed sync with tree_valid = 0: cnt ← 0 and the partial frame is dropped.
- acc_len is captured only at frame start; changes mid-frame take effect on the next frame.
- Latency from the din of the last frame sample to dout_valid is TREE_LAT + 1 cycles.
- dout holds its value between strobes. dout_valid is low in all other cycles.
- sync_in, acc_len and din_valid have no handshake or backpressure. The block accepts one sample per cycle at full rate.

Decomposition:
- Shared package:
  - clog2 function;
  - TREE_LAT / TREE_W / DOUT_WIDTH derivation functions;
  - extension helper keyed by SIGNED.
- Sub-module adder_tree_level: one registered reduction level (parameters N, W, SIGNED; handles the odd passthrough). The top instantiates it iteratively in a generate loop with no recursive self-instantiation, plus the valid/sync delay lines and the accumulator FSM (cnt, len_q, acc).

Test Plan:
- SIGNED=1, DIN=8, PARALLEL=10, acc_len=0, one valid beat of all −128 → tree_out = −1280 with tree_valid at cycle +4; dout = −1280 with dout_valid at cycle +5, single pulse.
- SIGNED=0, all lanes 255, PARALLEL=10 and PARALLEL=3 → tree_out = 2550 after 4 cycles and 765 after 2 cycles respectively. Checks odd lanes and zero extension.
- acc_len=3, all lanes 1, continuous valid → dout = 40 strobed every 4th cycle. Repeat with din_valid toggling 1/0 → dout = 40 every 8 cycles.
- acc_len=3, sync_in asserted on the 3rd sample of a frame → no dump for the partial frame; next dump is exactly 4 valid samples after the sync sample, value 40.
- acc_len changed 3→1 on the 2nd sample of a frame → current frame dumps after 4 samples (40), following frames after 2 (20).
- rst pulsed mid-frame, asynchronously between edges → all outputs 0 immediately. The first frame after release dumps after acc_len+1 samples. PARALLEL=1, DIN=4 signed, −8 input → tree_out = −8 after 1 cycle.
